// File: rtl/ifu_fetch_gen.sv
// Fetch PC generator with an AXI read-address channel, in-order response tags
// and jump squashing of in-flight fetches.
module ifu_fetch_gen #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       FETCH_BYTES = 8,
  parameter int unsigned       INST_BYTES  = 4,
  parameter int unsigned       MAX_OUTST   = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = ADDR_W'(32'h8000_0000),
  localparam int unsigned      SLOTS       = FETCH_BYTES / INST_BYTES,
  localparam int unsigned      CNT_W       = $clog2(MAX_OUTST + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              stall_pc_i,
  output logic              ar_valid_o,
  output logic [ADDR_W-1:0] ar_addr_o,
  input  logic              ar_ready_i,
  input  logic              r_valid_i,
  output logic              r_ready_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              fetch_valid_o,
  output logic [ADDR_W-1:0] fetch_pc_o,
  output logic [SLOTS-1:0]  slot_mask_o,
  output logic              stale_drop_o,
  output logic [CNT_W-1:0]  outst_cnt_o,
  output logic              resp_err_o
);

  localparam int unsigned       INST_LSB   = $clog2(INST_BYTES);
  localparam int unsigned       PTR_W      = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [ADDR_W-1:0] FETCH_MASK = ~ADDR_W'(FETCH_BYTES - 1);
  localparam logic [ADDR_W-1:0] INST_MASK  = ~ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] SLOT_MASK  = ADDR_W'(SLOTS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(MAX_OUTST);
  localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(MAX_OUTST - 1);

  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    arAddr_q, arAddr_d;
  logic                 arValid_q, arValid_d;
  logic                 killPend_q, killPend_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [ADDR_W-1:0]    tagPc_q [MAX_OUTST];
  logic [MAX_OUTST-1:0] tagStale_q, tagStale_d;
  logic                 fetchValid_q, fetchValid_d;
  logic                 staleDrop_q, staleDrop_d;
  logic                 respErr_q, respErr_d;
  logic [ADDR_W-1:0]    fetchPc_q, fetchPc_d;
  logic [SLOTS-1:0]     slotMask_q, slotMask_d;

  logic              handshake, popHead, headStale;
  logic [ADDR_W-1:0] headPc, headSlot;

  function automatic logic [PTR_W-1:0] bumpPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign handshake = arValid_q & ar_ready_i;
  assign popHead   = r_valid_i & (cnt_q != '0);
  assign headPc    = tagPc_q[rdPtr_q];
  assign headStale = tagStale_q[rdPtr_q];
  assign headSlot  = (headPc >> INST_LSB) & SLOT_MASK;

  always_comb begin
    pc_d         = pc_q;
    arAddr_d     = arAddr_q;
    arValid_d    = arValid_q;
    killPend_d   = killPend_q;
    cnt_d        = cnt_q;
    wrPtr_d      = wrPtr_q;
    rdPtr_d      = rdPtr_q;
    tagStale_d   = tagStale_q;
    fetchValid_d = 1'b0;
    staleDrop_d  = 1'b0;
    slotMask_d   = '0;
    fetchPc_d    = fetchPc_q;
    respErr_d    = respErr_q | (r_valid_i & (cnt_q == '0));

    // A killed request was already redirected, so its acceptance must not advance the PC.
    if (jump_flag_i)
      pc_d = jump_addr_i & INST_MASK;
    else if (handshake && !killPend_q)
      pc_d = arAddr_q + ADDR_W'(FETCH_BYTES);

    if (!arValid_q)
      arAddr_d = pc_q & FETCH_MASK;

    if (handshake)
      arValid_d = 1'b0;
    else if (!arValid_q)
      arValid_d = !stall_pc_i && !jump_flag_i && (cnt_q < CNT_MAX);

    if (handshake)
      killPend_d = 1'b0;
    else if (jump_flag_i && arValid_q)
      killPend_d = 1'b1;

    if (jump_flag_i)
      tagStale_d = '1;
    if (handshake) begin
      tagStale_d[wrPtr_q] = killPend_q | jump_flag_i;
      wrPtr_d             = bumpPtr(wrPtr_q);
    end
    if (popHead)
      rdPtr_d = bumpPtr(rdPtr_q);

    case ({handshake, popHead})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (popHead) begin
      if (!headStale && !jump_flag_i) begin
        fetchValid_d = 1'b1;
        fetchPc_d    = headPc;
        for (int k = 0; k < SLOTS; k++)
          slotMask_d[k] = (ADDR_W'(k) >= headSlot);
      end else begin
        staleDrop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_ADDR;
      arAddr_q     <= '0;
      arValid_q    <= 1'b0;
      killPend_q   <= 1'b0;
      cnt_q        <= '0;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      tagStale_q   <= '0;
      fetchValid_q <= 1'b0;
      staleDrop_q  <= 1'b0;
      slotMask_q   <= '0;
      fetchPc_q    <= '0;
      respErr_q    <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      arAddr_q     <= arAddr_d;
      arValid_q    <= arValid_d;
      killPend_q   <= killPend_d;
      cnt_q        <= cnt_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      tagStale_q   <= tagStale_d;
      fetchValid_q <= fetchValid_d;
      staleDrop_q  <= staleDrop_d;
      slotMask_q   <= slotMask_d;
      fetchPc_q    <= fetchPc_d;
      respErr_q    <= respErr_d;
    end
  end

  // Tag PCs are only meaningful once pushed, so they need no reset.
  always_ff @(posedge clk) begin
    if (handshake)
      tagPc_q[wrPtr_q] <= pc_q;
  end

  assign ar_valid_o    = arValid_q;
  assign ar_addr_o     = arValid_q ? arAddr_q : (pc_q & FETCH_MASK);
  assign r_ready_o     = ~rst;
  assign pc_o          = pc_q;
  assign fetch_valid_o = fetchValid_q;
  assign fetch_pc_o    = fetchPc_q;
  assign slot_mask_o   = slotMask_q;
  assign stale_drop_o  = staleDrop_q;
  assign outst_cnt_o   = cnt_q;
  assign resp_err_o    = respErr_q;

endmodule
